handshake_tx: RTL and testbench
===============================

Name: handshake_tx

Overview:
- Initiator (sending) end of a 4-phase req/ack handshake that carries a WIDTH-bit word into another clock domain.
- The receiving domain brings `req` in through its own 2-flop synchronizer and latches `dout` while `req` is high.
- This block accepts a one-cycle `send` strobe, holds `dout` and `req` stable until the receiver acknowledges, and synchronizes the asynchronous `ack` return internally.
- Sits between local control logic and the clock-domain-crossing boundary.

Parameters:
- WIDTH, 8, payload width in bits.
- SYNC_STAGES, 2, number of flops in the `ack` synchronizer chain; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- send  input  1  one-cycle request to transfer `din`.
- din  input  WIDTH  payload; sampled only on the accepting edge.
- clr_err  input  1  synchronous clear for `err`.
- ack  input  1  acknowledge from the other domain; asynchronous to `clk`.
- req  output  1  handshake request level, driven directly from a flop.
- dout  output  WIDTH  registered payload; stable for the whole time `req` is high and until `done`.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when the handshake completes.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, active low): req=0, dout=0, busy=0, done=0, err=0, all `ack` synchronizer flops=0, state=IDLE.
- Reset asserted mid-transfer drops `req` immediately; no `done` pulse is issued.
- ack_s is the output of the SYNC_STAGES-deep flop chain on `ack`. Only ack_s is used by the FSM.
- FSM states: IDLE, REQ, REL.
- IDLE:
  - busy=0.
  - If send=1 and ack_s=0: dout<=din, req<=1, go to REQ.
  - If send=1 and ack_s=1: treat as a protocol violation. err<=1, the send is dropped, stay in IDLE.
- REQ:
  - busy=1, req=1.
  - On ack_s=1: req<=0, go to REL.
- REL:
  - busy=1, req=0.
  - On ack_s=0: go to IDLE and set done<=1 for exactly one cycle.
- Acceptance timing: a send sampled at edge k gives req=1, busy=1 and dout=din(k) from edge k onward.
- Acknowledge latency: if `ack` rises before edge a, the first sync flop captures it at a, ack_s=1 after edge a+SYNC_STAGES-1, and req=0 after edge a+SYNC_STAGES.
- Release latency: the falling edge of `ack` follows the same latency to the transition into IDLE and the `done` pulse.
- done is registered and coincides with the first IDLE cycle. A `send` in that same cycle is accepted, so back-to-back transfers lose no cycles.
- send while busy=1: ignored; err<=1; dout and req are unchanged.
- err is sticky:
  - Cleared by clr_err=1 at the next edge.
  - If a set condition and clr_err occur in the same cycle, set wins.
- dout changes only on an accepting edge; it is never modified in REQ or REL.
- `ack` glitches shorter than a clock period may be missed. The receiver guarantees level-held `ack` per the 4-phase protocol, so this is acceptable.
- No timeout: the block waits indefinitely in REQ or REL.

Test Plan:
1. Single transfer, SYNC_STAGES=2:
   - Stimulus: send=1 with din=8'hA5 for one cycle; the model raises `ack` 3 cycles after seeing req, then lowers `ack` 3 cycles after req falls.
   - Required: req rises after the send edge; dout=8'hA5 until done; req falls exactly 2 edges after ack is first sampled high; done pulses once 2 edges after ack is first sampled low; busy falls with done.
2. Back-to-back transfers:
   - Stimulus: send with 8'h3C on the done cycle of the previous transfer.
   - Required: accepted; req re-rises the next cycle; dout=8'h3C; err=0.
3. Send while busy:
   - Stimulus: send=1 with din=8'hFF while in REQ.
   - Required: dout keeps its old value; err=1 and stays 1 until clr_err; after clr_err err=0 on the next edge.
4. Spurious ack:
   - Stimulus: hold ack=1 in IDLE for 3 cycles, then pulse send.
   - Required: send dropped; req stays 0; err=1.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 asynchronously between edges while in REQ.
   - Required: req, busy, dout, err all 0 immediately, without waiting for a clock edge; no done pulse; after release, a normal transfer with 8'h5A completes.
6. Latency with SYNC_STAGES=3:
   - Stimulus: a normal handshake.
   - Required: req falls 3 edges after ack is first sampled high; done pulses 3 edges after ack is first sampled low.

Source files
------------

// File: rtl/handshake_tx.sv
// -----------------------------------------------------------------------------
// handshake_tx
//
// Sending end of a 4-phase req/ack handshake that moves a WIDTH-bit word into
// another clock domain. The payload is captured on the accepting edge of a
// one-cycle `send` strobe. It is then held, together with `req`, until the
// receiver acknowledges. The asynchronous `ack` return is brought into the
// `clk` domain through a SYNC_STAGES-deep flop chain.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   send     in   one-cycle request to transfer din
//   din      in   payload, sampled only on the accepting edge
//   clr_err  in   synchronous clear of the sticky error flag
//   ack      in   acknowledge from the far domain (asynchronous)
//   req      out  handshake request level (flop output)
//   dout     out  registered payload, stable while a transfer is in flight
//   busy     out  high whenever a transfer is in progress
//   done     out  one-cycle pulse in the first idle cycle after completion
//   err      out  sticky protocol-error flag
//
// SYNC_STAGES must be 2 or more.
// -----------------------------------------------------------------------------
module handshake_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    input  logic             ack,
    output logic             req,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   err_set;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    // Synchronizer chain: stage 0 samples the raw ack. Each later stage
    // samples its predecessor. Only the last stage is seen by the FSM.
    assign ack_sync_d[0] = ack;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign ack_sync_d[gi] = ack_sync_q[gi-1];
        end
    endgenerate

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (send) begin
                    if (ack_s) begin
                        // The receiver is still acknowledging something, so
                        // starting a new transfer would break the 4-phase
                        // sequence. Drop the send and flag the violation.
                        err_set = 1'b1;
                    end else begin
                        dout_d  = din;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (send) err_set = 1'b1;
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (send) err_set = 1'b1;
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Set takes priority over clear, so an error raised in the same cycle
        // as clr_err is not lost.
        if (err_set)      err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign req  = req_q;
    assign dout = dout_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_handshake_tx
//
// Self-checking bench for handshake_tx. Two instances share the stimulus. One
// has SYNC_STAGES=2 and the other has SYNC_STAGES=3. `sel` picks which
// instance is observed. The bench plays the receiver by driving `ack`.
// Accepted payloads are pushed to a scoreboard queue. They are popped and
// compared against dout when the done pulse appears.
// -----------------------------------------------------------------------------
module tb_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] din;
    logic       clr_err;
    logic       ack;

    logic       req2, busy2, done2, err2;
    logic [7:0] dout2;
    logic       req3, busy3, done3, err3;
    logic [7:0] dout3;

    logic       sel;
    logic       req_o, busy_o, done_o, err_o;
    logic [7:0] dout_o;
    int         lat;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    handshake_tx #(.WIDTH(8), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .send(send), .din(din), .clr_err(clr_err),
        .ack(ack), .req(req2), .dout(dout2), .busy(busy2), .done(done2),
        .err(err2)
    );

    handshake_tx #(.WIDTH(8), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .send(send), .din(din), .clr_err(clr_err),
        .ack(ack), .req(req3), .dout(dout3), .busy(busy3), .done(done3),
        .err(err3)
    );

    assign req_o  = sel ? req3  : req2;
    assign busy_o = sel ? busy3 : busy2;
    assign done_o = sel ? done3 : done2;
    assign err_o  = sel ? err3  : err2;
    assign dout_o = sel ? dout3 : dout2;
    assign lat    = sel ? 3 : 2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse send with d and check the transfer was accepted on that edge.
    task automatic start(input logic [7:0] d);
        send = 1'b1;
        din  = d;
        tick();
        send = 1'b0;
        din  = 8'h00;
        chk("acc_req",  req_o,  1);
        chk("acc_busy", busy_o, 1);
        chk("acc_dout", dout_o, d);
        chk("acc_done", done_o, 0);
        exp_q.push_back(d);
    endtask

    // Act as the receiver: raise ack, wait for req to drop, lower ack, and
    // wait for done. Returns in the done cycle.
    task automatic finish();
        int         n;
        logic [7:0] e;
        repeat (2) tick();
        ack = 1'b1;
        tick();                              // edge a: ack first sampled high
        chk("req_held", req_o, 1);
        n = 0;
        while (req_o && n <= 20) begin
            tick();
            n++;
            if (exp_q.size() > 0) chk("dout_stable", dout_o, exp_q[0]);
        end
        chk("ack_lat", n, lat);
        repeat (2) tick();
        ack = 1'b0;
        tick();                              // edge b: ack first sampled low
        chk("done_early", done_o, 0);
        n = 0;
        while (!done_o && n <= 20) begin
            tick();
            n++;
        end
        chk("rel_lat", n, lat);
        chk("done_busy", busy_o, 0);
        chk("done_req",  req_o,  0);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_dout", dout_o, e);
            $display("xfer sel=%0d dout=%02h exp=%02h lat=%0d", sel, dout_o, e, lat);
        end
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; send = 1'b0; din = 8'h00;
        clr_err = 1'b0; ack = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_req",  req_o,  0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err",  err_o,  0);
        chk("rst_dout", dout_o, 0);
        rst_n = 1'b1;
        tick();

        // 1 + 2: single transfer followed by a back-to-back transfer on the done cycle
        start(8'hA5);
        finish();
        start(8'h3C);
        chk("b2b_err", err_o, 0);
        finish();
        tick();
        chk("done_1cyc", done_o, 0);

        // 3: send while busy, set-wins-over-clear, then clear
        start(8'h11);
        send = 1'b1; din = 8'hFF;
        tick();
        send = 1'b0;
        chk("busy_dout", dout_o, 8'h11);
        chk("busy_req",  req_o,  1);
        chk("busy_err",  err_o,  1);
        repeat (3) tick();
        chk("err_sticky", err_o, 1);
        clr_err = 1'b1; send = 1'b1;
        tick();
        send = 1'b0;
        chk("err_setwins", err_o, 1);
        tick();
        clr_err = 1'b0;
        chk("err_clr", err_o, 0);
        finish();
        tick();

        // 4: spurious ack while idle
        ack = 1'b1;
        repeat (3) tick();
        send = 1'b1; din = 8'h99;
        tick();
        send = 1'b0;
        chk("spur_req",  req_o,  0);
        chk("spur_busy", busy_o, 0);
        chk("spur_err",  err_o,  1);
        chk("spur_dout", dout_o, 8'h11);
        ack = 1'b0;
        repeat (4) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("spur_clr", err_o, 0);

        // 5: asynchronous reset mid-transfer
        start(8'h77);
        send = 1'b1; din = 8'hFF;
        tick();
        send = 1'b0;
        chk("pre_rst_err", err_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",  req_o,  0);
        chk("arst_busy", busy_o, 0);
        chk("arst_dout", dout_o, 0);
        chk("arst_err",  err_o,  0);
        exp_q.delete();
        tick();
        chk("arst_done", done_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", done_o, 0);
        start(8'h5A);
        finish();
        tick();

        // 6: three-stage synchronizer latency
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sel = 1'b1;
        tick();
        start(8'hC3);
        finish();
        tick();
        chk("s3_done_1cyc", done_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
